// File: rtl/pcpi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcpi_pkg
//  Description : Shared constants, state encoding and instruction-word
//                encoder for the PCPI initiator and its testbench.
//  Contents    : OPCODE_OP / FUNCT7_MULDIV, M-extension funct3 codes,
//                pcpi_state_e, encode_muldiv()
//  Revision    : 1.0 - initial release
// ============================================================================
package pcpi_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } pcpi_state_e;

    // R-type M-extension word: funct7 | rs2 | rs1 | funct3 | rd | opcode
    function automatic logic [31:0] encode_muldiv(
        input logic [2:0] funct3,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return {FUNCT7_MULDIV, rs2, rs1, funct3, rd, OPCODE_OP};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcpi_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : pcpi_initiator
//  Description : CPU-side PCPI requester. Accepts one M-extension operation
//                on a valid/ready command port, issues it to a PCPI
//                co-processor and returns the result, or an error if nobody
//                claims the instruction within TIMEOUT edges.
//  Ports       : clk, reset (async, active-high)
//                req_*  : command port (valid/ready, funct3, reg indices,
//                         operand values)
//                pcpi_* : PCPI request (valid, insn, rs1, rs2) and
//                         co-processor reply (wr, rd, wait, ready)
//                rsp_*  : response port (valid/ready, data, wr, err,
//                         rd_idx, cycles)
//  Revision    : 1.0 - initial release
// ============================================================================
module pcpi_initiator
    import pcpi_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    // command port
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [4:0]       req_rd_idx,
    input  logic [4:0]       req_rs1_idx,
    input  logic [4:0]       req_rs2_idx,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    // PCPI interface
    output logic             pcpi_valid,
    output logic [31:0]      pcpi_insn,
    output logic [XLEN-1:0]  pcpi_rs1,
    output logic [XLEN-1:0]  pcpi_rs2,
    input  logic             pcpi_wr,
    input  logic [XLEN-1:0]  pcpi_rd,
    input  logic             pcpi_wait,
    input  logic             pcpi_ready,
    // response port
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic             rsp_wr,
    output logic             rsp_err,
    output logic [4:0]       rsp_rd_idx,
    output logic [CNT_W-1:0] rsp_cycles
);

    localparam logic [7:0]       c_TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CYCLES_MAX   = '1;

    pcpi_state_e      r_state;
    pcpi_state_e      w_state_next;

    logic             r_pcpi_valid;
    logic [31:0]      r_pcpi_insn;
    logic [XLEN-1:0]  r_pcpi_rs1;
    logic [XLEN-1:0]  r_pcpi_rs2;
    logic [4:0]       r_rd_idx;
    logic [7:0]       r_timeout_cnt;
    logic             r_wait_seen;
    logic [CNT_W-1:0] r_cycles;
    logic             r_rsp_valid;
    logic [XLEN-1:0]  r_rsp_data;
    logic             r_rsp_wr;
    logic             r_rsp_err;

    // Once a co-processor has claimed the instruction via pcpi_wait, the
    // timeout is disarmed for the rest of the operation.
    logic             w_timeout_hit;
    assign w_timeout_hit = !r_wait_seen && (r_timeout_cnt == c_TIMEOUT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; ready outranks wait, wait outranks timeout.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (pcpi_ready) begin
                    w_state_next = RESP;
                end else if (!pcpi_wait && w_timeout_hit) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, counters and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcpi_valid  <= 1'b0;
            r_pcpi_insn   <= '0;
            r_pcpi_rs1    <= '0;
            r_pcpi_rs2    <= '0;
            r_rd_idx      <= '0;
            r_timeout_cnt <= '0;
            r_wait_seen   <= 1'b0;
            r_cycles      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_wr      <= 1'b0;
            r_rsp_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_pcpi_valid  <= 1'b1;
                        r_pcpi_insn   <= encode_muldiv(req_funct3, req_rd_idx,
                                                       req_rs1_idx, req_rs2_idx);
                        r_pcpi_rs1    <= req_rs1;
                        r_pcpi_rs2    <= req_rs2;
                        r_rd_idx      <= req_rd_idx;
                        r_timeout_cnt <= '0;
                        r_wait_seen   <= 1'b0;
                        r_cycles      <= '0;
                    end
                end
                ISSUE: begin
                    // Counts every ISSUE edge, including the one that ends it.
                    if (r_cycles != c_CYCLES_MAX) begin
                        r_cycles <= r_cycles + 1'b1;
                    end
                    if (pcpi_ready) begin
                        r_pcpi_valid <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_data   <= pcpi_rd;
                        r_rsp_wr     <= pcpi_wr;
                        r_rsp_err    <= 1'b0;
                    end else if (pcpi_wait) begin
                        r_wait_seen <= 1'b1;
                    end else if (w_timeout_hit) begin
                        r_pcpi_valid <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_data   <= '0;
                        r_rsp_wr     <= 1'b0;
                        r_rsp_err    <= 1'b1;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign pcpi_valid = r_pcpi_valid;
    assign pcpi_insn  = r_pcpi_insn;
    assign pcpi_rs1   = r_pcpi_rs1;
    assign pcpi_rs2   = r_pcpi_rs2;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_wr     = r_rsp_wr;
    assign rsp_err    = r_rsp_err;
    assign rsp_rd_idx = r_rd_idx;
    assign rsp_cycles = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pcpi_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcpi_initiator
//  Description : Self-checking bench for pcpi_initiator. A behavioural
//                co-processor stub answers each issued instruction with the
//                M-extension result computed by a reference model, using a
//                per-operation schedule of wait/ready edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcpi_initiator;
    import pcpi_pkg::*;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic [4:0]       req_rd_idx;
    logic [4:0]       req_rs1_idx;
    logic [4:0]       req_rs2_idx;
    logic [XLEN-1:0]  req_rs1;
    logic [XLEN-1:0]  req_rs2;
    logic             pcpi_valid;
    logic [31:0]      pcpi_insn;
    logic [XLEN-1:0]  pcpi_rs1;
    logic [XLEN-1:0]  pcpi_rs2;
    logic             pcpi_wr;
    logic [XLEN-1:0]  pcpi_rd;
    logic             pcpi_wait;
    logic             pcpi_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  rsp_data;
    logic             rsp_wr;
    logic             rsp_err;
    logic [4:0]       rsp_rd_idx;
    logic [CNT_W-1:0] rsp_cycles;

    int               n_checks;
    int               n_errors;
    logic [31:0]      last_data;

    pcpi_initiator #(
        .XLEN    (XLEN),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct3  (req_funct3),
        .req_rd_idx  (req_rd_idx),
        .req_rs1_idx (req_rs1_idx),
        .req_rs2_idx (req_rs2_idx),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .pcpi_valid  (pcpi_valid),
        .pcpi_insn   (pcpi_insn),
        .pcpi_rs1    (pcpi_rs1),
        .pcpi_rs2    (pcpi_rs2),
        .pcpi_wr     (pcpi_wr),
        .pcpi_rd     (pcpi_rd),
        .pcpi_wait   (pcpi_wait),
        .pcpi_ready  (pcpi_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_wr      (rsp_wr),
        .rsp_err     (rsp_err),
        .rsp_rd_idx  (rsp_rd_idx),
        .rsp_cycles  (rsp_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics in plain 64-bit arithmetic.
    function automatic logic [31:0] ref_muldiv(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'b000: begin p = ua * ub; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // One full operation. The stub asserts pcpi_wait continuously from edge
    // wait_edge (0 = never) and pulses pcpi_ready at edge ready_edge
    // (0 = never); edges are numbered from 1 after acceptance.
    // bp stalls the response that many cycles; chain re-raises req_valid on
    // the response handshake edge.
    task automatic do_op(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [31:0] a, input logic [31:0] b,
                         input int ready_edge, input int wait_edge, input int bp, input bit chain);
        logic [31:0] exp_insn;
        logic [31:0] exp_res;
        logic        stub_wr;
        bit          exp_err;
        int          exp_cyc;
        int          k;
        bit          done;
        exp_insn = {7'b0000001, r2, r1, f3, rd, 7'b0110011};
        exp_res  = ref_muldiv(f3, a, b);
        stub_wr  = 1'($urandom_range(0, 1));
        exp_err  = !(ready_edge >= 1 && ready_edge <= TIMEOUT) &&
                   !(wait_edge  >= 1 && wait_edge  <= TIMEOUT);
        exp_cyc  = exp_err ? TIMEOUT : ready_edge;

        @(negedge clk);
        req_funct3 = f3; req_rd_idx = rd; req_rs1_idx = r1; req_rs2_idx = r2;
        req_rs1 = a; req_rs2 = b; req_valid = 1'b1;
        check_val("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("pcpi_valid_issue", pcpi_valid, 1);
        check_val("req_ready_issue", req_ready, 0);
        check_val("pcpi_insn", pcpi_insn, exp_insn);
        check_val("pcpi_rs1", pcpi_rs1, a);
        check_val("pcpi_rs2", pcpi_rs2, b);

        k = 0; done = 0;
        while (!done && k < 200) begin
            k++;
            @(negedge clk);
            pcpi_wait  = (wait_edge > 0 && k >= wait_edge);
            pcpi_ready = (k == ready_edge);
            pcpi_rd    = exp_res;
            pcpi_wr    = stub_wr;
            @(posedge clk); #1;
            pcpi_ready = 1'b0;
            pcpi_wait  = 1'b0;
            if (!pcpi_valid) done = 1;
            else check_val("insn_hold", pcpi_insn, exp_insn);
        end
        check_val("valid_high_cycles", k, exp_cyc);
        check_val("rsp_valid", rsp_valid, 1);
        check_val("rsp_err", rsp_err, exp_err);
        check_val("rsp_data", rsp_data, exp_err ? 32'h0 : exp_res);
        check_val("rsp_wr", rsp_wr, exp_err ? 1'b0 : stub_wr);
        check_val("rsp_cycles", rsp_cycles, exp_cyc);
        check_val("rsp_rd_idx", rsp_rd_idx, rd);
        check_val("req_ready_resp", req_ready, 0);
        last_data = rsp_data;

        // Stalled response; a stray pcpi_ready must not disturb it.
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            pcpi_ready = 1'b1;
            pcpi_rd    = ~exp_res;
            @(posedge clk); #1;
            pcpi_ready = 1'b0;
            check_val("bp_rsp_valid", rsp_valid, 1);
            check_val("bp_rsp_data", rsp_data, exp_err ? 32'h0 : exp_res);
            check_val("bp_req_ready", req_ready, 0);
        end

        @(negedge clk);
        rsp_ready = 1'b1;
        if (chain) req_valid = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_val("rsp_valid_drop", rsp_valid, 0);
        check_val("no_same_edge_accept", pcpi_valid, 0);
        check_val("req_ready_back", req_ready, 1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_checks = 0; n_errors = 0; last_data = '0;
        reset = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_rd_idx = '0;
        req_rs1_idx = '0; req_rs2_idx = '0; req_rs1 = '0; req_rs2 = '0;
        pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0; pcpi_ready = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_pcpi_valid", pcpi_valid, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_err", rsp_err, 0);
        check_val("rst_rsp_data", rsp_data, 0);
        check_val("rst_rsp_cycles", rsp_cycles, 0);
        check_val("rst_pcpi_insn", pcpi_insn, 0);
        check_val("rst_req_ready", req_ready, 1);
        @(negedge clk);
        reset = 1'b0;

        // DIVU 20/3 answered on edge 5, with a fixed-encoding check.
        do_op(DIVU, 5'd0, 5'd20, 5'd3, 32'd20, 32'd3, 5, 1, 0, 0);
        check_val("divu_result", last_data, 32'd6);
        check_val("divu_insn_word", encode_muldiv(DIVU, 5'd0, 5'd20, 5'd3), 32'h023A_5033);

        // Back-to-back REM then DIV overflow case.
        do_op(REM, 5'd7, 5'd1, 5'd2, 32'hFFFF_FFEC, 32'd3, 9, 2, 0, 1);
        check_val("rem_result", last_data, 32'hFFFF_FFFE);
        do_op(DIV, 5'd8, 5'd3, 5'd4, 32'h8000_0000, 32'hFFFF_FFFF, 12, 2, 0, 0);
        check_val("div_ovf_result", last_data, 32'h8000_0000);

        // Nobody claims: timeout.
        do_op(MUL, 5'd9, 5'd5, 5'd6, 32'd7, 32'd9, 0, 0, 0, 0);
        // Claimed at edge 2, completes at edge 40.
        do_op(DIVU, 5'd10, 5'd5, 5'd6, 32'd1000, 32'd7, 40, 2, 0, 0);
        // Ready exactly on the timeout edge.
        do_op(MULHU, 5'd11, 5'd5, 5'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, TIMEOUT, 0, 0, 0);
        // Ready and wait together.
        do_op(MULH, 5'd12, 5'd5, 5'd6, 32'h8000_0000, 32'd3, 4, 4, 0, 0);
        // Response backpressure.
        do_op(REMU, 5'd13, 5'd5, 5'd6, 32'd100, 32'd0, 3, 0, 5, 0);

        // Reset during ISSUE of a DIV.
        @(negedge clk);
        req_funct3 = DIV; req_rd_idx = 5'd14; req_rs1_idx = 5'd1; req_rs2_idx = 5'd2;
        req_rs1 = 32'd77; req_rs2 = 32'd5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            pcpi_wait = (k >= 2);
            @(posedge clk);
        end
        #2 reset = 1'b1;
        #1;
        check_val("mid_rst_pcpi_valid", pcpi_valid, 0);
        check_val("mid_rst_rsp_valid", rsp_valid, 0);
        check_val("mid_rst_req_ready", req_ready, 1);
        pcpi_wait = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pcpi_ready = 1'b1; pcpi_rd = 32'h1234; pcpi_wr = 1'b1;
        @(posedge clk); #1;
        pcpi_ready = 1'b0;
        check_val("late_ready_rsp_valid", rsp_valid, 0);
        check_val("late_ready_pcpi_valid", pcpi_valid, 0);
        do_op(DIV, 5'd14, 5'd1, 5'd2, 32'd77, 32'd5, 6, 2, 0, 0);
        check_val("post_rst_div", last_data, 32'd15);

        // Randomized operations and co-processor schedules.
        for (int n = 0; n < 24; n++) begin
            int mode;
            int re;
            int we;
            mode = $urandom_range(0, 3);
            case (mode)
                0:       begin re = $urandom_range(1, TIMEOUT); we = 0; end
                1:       begin we = $urandom_range(1, TIMEOUT); re = we + $urandom_range(0, 30); end
                2:       begin re = 0; we = 0; end
                default: begin re = 0; we = TIMEOUT + 1 + $urandom_range(0, 4); end
            endcase
            do_op(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
                  pick_operand(), pick_operand(), re, we, $urandom_range(0, 2), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
